// File: rtl/ins_fetch.sv
// Instruction fetch/issue sequencer: reads opcode and optional immediate bytes from synchronous
// program memory, presents them to the decoder for one EXEC step, and applies jump/halt results.
module ins_fetch #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        ir,
  output logic [3:0]        rf,
  output logic              en,
  output logic [DATA_W-1:0] imm,
  input  logic              jmp_i,
  input  logic              jg_i,
  input  logic              gt_flag,
  input  logic              halt_i,
  input  logic              in_valid,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    StFetch,
    StLoad,
    StImmRd,
    StImmLd,
    StExec,
    StHalt
  } state_e;

  localparam logic [3:0] OpJmp  = 4'b1010;
  localparam logic [3:0] OpJg   = 4'b1011;
  localparam logic [3:0] OpMovi = 4'b1110;
  localparam logic [3:0] OpIn1  = 4'b1100;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [3:0]          op_q, op_d;
  logic [3:0]          rf_q, rf_d;
  logic [DATA_W-1:0]   imm_q, imm_d;

  logic two_byte;
  logic in_stall;
  logic take_jump;

  assign two_byte  = (mem_rdata[7:4] == OpJmp) || (mem_rdata[7:4] == OpJg) ||
                     (mem_rdata[7:4] == OpMovi);
  assign in_stall  = (op_q == OpIn1) && !in_valid;
  assign take_jump = jmp_i || (jg_i && gt_flag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      op_q    <= '0;
      rf_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      rf_q    <= rf_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    rf_d    = rf_q;
    imm_d   = imm_q;
    case (state_q)
      StFetch: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = StLoad;
      end
      StLoad: begin
        op_d    = mem_rdata[7:4];
        rf_d    = mem_rdata[3:0];
        state_d = two_byte ? StImmRd : StExec;
      end
      StImmRd: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = StImmLd;
      end
      StImmLd: begin
        imm_d   = mem_rdata;
        state_d = StExec;
      end
      StExec: begin
        // Halt takes priority over a simultaneous jump; pc is not reloaded.
        if (in_stall) begin
          state_d = StExec;
        end else if (halt_i) begin
          state_d = StHalt;
        end else begin
          if (take_jump) pc_d = imm_q[PC_W-1:0];
          state_d = StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Outputs are forced to reset values combinationally so no read issues in the reset cycle.
  always_comb begin
    mem_rd   = 1'b0;
    en       = 1'b0;
    ir       = 4'b0000;
    halted   = 1'b0;
    mem_addr = rst ? '0 : pc_q;
    if (!rst) begin
      case (state_q)
        StFetch, StImmRd: mem_rd = 1'b1;
        StExec: begin
          en = 1'b1;
          ir = op_q;
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc  = pc_q;
  assign rf  = rf_q;
  assign imm = imm_q;

endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
Instruction fetch/issue sequencer that drives the 4-bit opcode bus (ir) and execute enable (en) consumed by the instruction decoder.
- Reads instruction bytes from synchronous program memory and maintains the PC.
- Fetches the immediate byte for two-byte instructions.
- Holds execute for the input handshake and applies jump/jg/halt results from the decoder.

Parameters:
PC_W, 8, program counter / memory address width
DATA_W, 8, program memory data width (must be 8: opcode [7:4], register field [3:0])

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
mem_addr  output  PC_W  program memory read address
mem_rd  output  1  program memory read strobe; data valid on mem_rdata the following cycle
mem_rdata  input  DATA_W  program memory read data
ir  output  4  opcode to decoder
rf  output  4  register field of current instruction
en  output  1  execute enable to decoder
imm  output  DATA_W  immediate/target byte of two-byte instruction
jmp_i  input  1  decoded jmp
jg_i  input  1  decoded jg
gt_flag  input  1  ALU greater-than flag
halt_i  input  1  decoded halt
in_valid  input  1  external input data valid (for in1, opcode 1100)
pc  output  PC_W  current program counter
halted  output  1  high while in HALT

Behaviour:
- Reset values, also held while rst=1: state=FETCH, pc=0, ir=0000, rf=0, imm=0, en=0, mem_rd=0, mem_addr=0, halted=0.
- Two-byte opcodes: 1010 (jmp), 1011 (jg), 1110 (movi). All other opcodes are one byte.
- Opcode 0000 and undefined 0011 are NOPs: one EXEC cycle with no effect.

State machine:
- FETCH:
  - mem_rd=1, mem_addr=pc; pc<=pc+1.
  - Next: LOAD.
- LOAD:
  - Latch internal opcode<=mem_rdata[7:4] and rf<=mem_rdata[3:0].
  - Next: IMM_RD if the opcode is two-byte, else EXEC.
- IMM_RD:
  - mem_rd=1, mem_addr=pc; pc<=pc+1.
  - Next: IMM_LD.
- IMM_LD:
  - imm<=mem_rdata.
  - Next: EXEC.
- EXEC:
  - en=1 and ir=latched opcode.
  - If opcode=1100 and in_valid=0: stay in EXEC, with en and ir held stable.
  - Else if halt_i: next state HALT.
  - Else if jmp_i, or (jg_i and gt_flag): pc<=imm[PC_W-1:0], then FETCH.
  - Otherwise: FETCH.
- HALT:
  - halted=1, en=0, mem_rd=0; pc frozen.
  - Leaves only via rst.

ir/en rules:
- ir is driven 0000 in every state except EXEC.
- Reason: the decoder decodes push (0001) and pop (0010) even when en=0, so any other ir value outside EXEC would trigger a spurious stack operation.
- en is high only in EXEC.

Latency:
- One-byte instruction: 3 cycles (FETCH, LOAD, EXEC).
- Two-byte instruction: 5 cycles.
- in1 adds one cycle per cycle that in_valid is low.

Boundary conditions:
- pc increments modulo 2^PC_W; 255+1 wraps to 0.
- An immediate fetched at address 255 reads from address 255 with pc->0.
- jg with gt_flag=0 is a fall-through; pc stays at instruction address+2.
- Jump target equal to the current instruction address is legal (tight loop).
- Simultaneous halt_i and jmp_i in EXEC: halt wins; pc is not loaded.
- rst asserted in any state, including mid-IMM_RD or during an in1 stall, returns all outputs to reset values at that edge.
- No memory read issues in the reset cycle.

Test Plan:
- Reset, mem[0]=0x80 (add), mem[1]=0xF0 (halt) -> en pulses in cycle 3 with ir=1000, rf=0; en in cycle 6 with ir=1111; halted=1 from cycle 7; pc=2 frozen; mem_rd stays 0 afterwards.
- mem[0]=0xE3, mem[1]=0x5A (movi) -> imm=0x5A, rf=3, ir=1110 with en in cycle 5; pc=2 at next FETCH.
- mem[4]=0xA0, mem[5]=0x04 (jmp 4), decoder jmp_i fed back -> pc reloads to 4 each loop; FETCH addresses repeat 4,5,4,5.
- jg to 0x10 with gt_flag=1 -> next fetch address 0x10; same with gt_flag=0 -> next fetch address is instruction address+2.
- mem[0]=0xC0 (in1), in_valid low 3 cycles then high -> en=1 with ir=1100 for 4 consecutive cycles; ir=0000 in all non-EXEC cycles, so no push/pop decode.
- Start pc at 255 via jmp 0xFF, mem[255]=0xE0, mem[0]=0x77 -> imm=0x77 and pc=1; separately, rst asserted during IMM_RD -> pc=0, en=0, ir=0000 on the next edge.
